// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_port_arbiter_pkg
// Brief   : Owner encodings, FSM states and ack decode shared by the arbiter.
// Revision: 1.0  initial release
// ============================================================================
package sdram_port_arbiter_pkg;

  localparam logic [1:0] c_OWNER_NONE = 2'd0;
  localparam logic [1:0] c_OWNER_VGA  = 2'd1;
  localparam logic [1:0] c_OWNER_CPU  = 2'd2;
  localparam logic [1:0] c_OWNER_AUX  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Ack vector ordering is {aux, cpu, vga}.
  function automatic logic [2:0] owner_to_ack(input logic [1:0] owner);
    case (owner)
      c_OWNER_VGA: owner_to_ack = 3'b001;
      c_OWNER_CPU: owner_to_ack = 3'b010;
      c_OWNER_AUX: owner_to_ack = 3'b100;
      default:     owner_to_ack = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_select.sv
`default_nettype none
// ============================================================================
// Module  : sdram_port_arbiter_select
// Brief   : Combinational winner pick: vga first unless starving the low pair,
//           cpu/aux alternate on ties.
// Revision: 1.0  initial release
// ============================================================================
module sdram_port_arbiter_select
  import sdram_port_arbiter_pkg::*;
(
  input  logic       i_vga_req,
  input  logic       i_cpu_req,
  input  logic       i_aux_req,
  input  logic       i_last_low_aux,
  input  logic       i_starve,
  output logic       o_any_req,
  output logic [1:0] o_winner
);

  logic       w_low_pend;
  logic [1:0] w_low_pick;

  assign w_low_pend = i_cpu_req | i_aux_req;
  assign o_any_req  = i_vga_req | w_low_pend;

  always_comb begin
    w_low_pick = c_OWNER_CPU;
    if (i_cpu_req && i_aux_req) begin
      w_low_pick = i_last_low_aux ? c_OWNER_CPU : c_OWNER_AUX;
    end else if (i_aux_req) begin
      w_low_pick = c_OWNER_AUX;
    end

    o_winner = c_OWNER_NONE;
    if (i_vga_req && !i_starve) begin
      o_winner = c_OWNER_VGA;
    end else if (w_low_pend) begin
      o_winner = w_low_pick;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdram_port_arbiter
// Brief   : Shares one SDRAM controller port between vga, cpu and aux with a
//           single word in flight and a starvation guard on vga priority.
// Revision: 1.0  initial release
// ============================================================================
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_wr,
  input  logic [DATA_W-1:0] vga_wdata,
  input  logic [1:0]        vga_bytesel,
  output logic              vga_ack,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_bytesel,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              aux_wr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [1:0]        aux_bytesel,
  output logic              aux_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              sd_req,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_wr,
  output logic [DATA_W-1:0] sd_wdata,
  output logic [1:0]        sd_bytesel,
  input  logic              sd_ack,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic [1:0]        owner
);

  localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_grant_en;
  logic              w_any_req;
  logic              w_low_pend;
  logic              w_starve;
  logic [1:0]        w_winner;
  logic [1:0]        r_owner;
  logic [7:0]        r_starve_cnt;
  logic              r_last_low_aux;
  logic [2:0]        w_ack;

  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_wr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [1:0]        w_sel_bytesel;

  logic [ADDR_W-1:0] r_sd_addr;
  logic              r_sd_wr;
  logic [DATA_W-1:0] r_sd_wdata;
  logic [1:0]        r_sd_bytesel;
  logic [DATA_W-1:0] r_rdata;

  assign w_low_pend = cpu_req | aux_req;
  assign w_starve   = w_low_pend && (r_starve_cnt == c_STARVE_LIMIT);

  sdram_port_arbiter_select u_select (
    .i_vga_req      (vga_req),
    .i_cpu_req      (cpu_req),
    .i_aux_req      (aux_req),
    .i_last_low_aux (r_last_low_aux),
    .i_starve       (w_starve),
    .o_any_req      (w_any_req),
    .o_winner       (w_winner)
  );

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (sd_ack) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_addr    = '0;
    w_sel_wr      = 1'b0;
    w_sel_wdata   = '0;
    w_sel_bytesel = 2'b00;
    case (w_winner)
      c_OWNER_VGA: begin
        w_sel_addr    = vga_addr;
        w_sel_wr      = vga_wr;
        w_sel_wdata   = vga_wdata;
        w_sel_bytesel = vga_bytesel;
      end
      c_OWNER_CPU: begin
        w_sel_addr    = cpu_addr;
        w_sel_wr      = cpu_wr;
        w_sel_wdata   = cpu_wdata;
        w_sel_bytesel = cpu_bytesel;
      end
      c_OWNER_AUX: begin
        w_sel_addr    = aux_addr;
        w_sel_wr      = aux_wr;
        w_sel_wdata   = aux_wdata;
        w_sel_bytesel = aux_bytesel;
      end
      default: begin
        w_sel_addr    = '0;
        w_sel_wr      = 1'b0;
        w_sel_wdata   = '0;
        w_sel_bytesel = 2'b00;
      end
    endcase
  end

  // Controller-facing fields only move at grant so they stay quiet between words.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_sd_addr    <= '0;
      r_sd_wr      <= 1'b0;
      r_sd_wdata   <= '0;
      r_sd_bytesel <= 2'b00;
      r_owner      <= c_OWNER_NONE;
    end else if (w_grant_en) begin
      r_sd_addr    <= w_sel_addr;
      r_sd_wr      <= w_sel_wr;
      r_sd_wdata   <= w_sel_wdata;
      r_sd_bytesel <= w_sel_bytesel;
      r_owner      <= w_winner;
    end else if (r_state == ST_DONE) begin
      r_owner      <= c_OWNER_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_rdata <= '0;
    end else if ((r_state == ST_BUSY) && sd_ack) begin
      r_rdata <= sd_rdata;
    end
  end

  // Counts vga wins while cpu/aux wait; at the limit the low pair gets one turn.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_starve_cnt   <= 8'd0;
      r_last_low_aux <= 1'b1;
    end else begin
      if (!w_low_pend) begin
        r_starve_cnt <= 8'd0;
      end else if (w_grant_en) begin
        if (w_winner == c_OWNER_VGA) begin
          if (r_starve_cnt != c_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
          end
        end else begin
          r_starve_cnt <= 8'd0;
        end
      end
      if (w_grant_en && (w_winner == c_OWNER_CPU)) begin
        r_last_low_aux <= 1'b0;
      end else if (w_grant_en && (w_winner == c_OWNER_AUX)) begin
        r_last_low_aux <= 1'b1;
      end
    end
  end

  assign w_ack = (r_state == ST_DONE) ? owner_to_ack(r_owner) : 3'b000;

  assign vga_ack    = w_ack[0];
  assign cpu_ack    = w_ack[1];
  assign aux_ack    = w_ack[2];
  assign rdata      = r_rdata;
  assign sd_req     = (r_state == ST_BUSY);
  assign sd_addr    = r_sd_addr;
  assign sd_wr      = r_sd_wr;
  assign sd_wdata   = r_sd_wdata;
  assign sd_bytesel = r_sd_bytesel;
  assign owner      = r_owner;

endmodule
`default_nettype wire
